program_loader: RTL and testbench

Byte-stream program loader that drives the load side (port B) of the four-bank instruction/data BRAM. It accepts a framed byte stream from a serial receiver, packs bytes little-endian into 32-bit words, and writes them one word per write cycle through the load bus. It checks an 8-bit payload checksum and reports done or error. The core is held off via `io_busy` until a load completes.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/loader_word_packer.sv | 75 +++++++
 rtl/program_loader.sv | 166 ++++++++++++++++
 tb/tb_program_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the byte-stream program loader.
//   state_e    : loader FSM states
//   LEN_BYTES  : number of little-endian length bytes that open a frame
//   WORD_BYTES : number of payload bytes packed into one 32-bit memory word
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/loader_word_packer.sv
// -----------------------------------------------------------------------------
// loader_word_packer
// Packs accepted payload bytes little-endian into four byte lanes and keeps
// the running 8-bit payload checksum.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   byte_in          : payload byte
//   accept           : byte_in is consumed this cycle
//   clear            : restart byte position and checksum (new frame)
//   lane_0..lane_3   : packed word, lane 0 holds the first byte of the word
//   word_full        : the next accepted byte completes the current word
//   checksum         : sum of all accepted payload bytes, mod 256
// -----------------------------------------------------------------------------
module loader_word_packer
  import loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       accept,
  input  logic       clear,
  output logic [7:0] lane_0,
  output logic [7:0] lane_1,
  output logic [7:0] lane_2,
  output logic [7:0] lane_3,
  output logic       word_full,
  output logic [7:0] checksum
);

  logic [1:0]                  byte_cnt_q, byte_cnt_d;
  logic [WORD_BYTES-1:0][7:0]  lane_q, lane_d;
  logic [7:0]                  sum_q, sum_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    byte_cnt_d = byte_cnt_q;
    lane_d     = lane_q;
    sum_d      = sum_q;
    if (clear) begin
      byte_cnt_d = '0;
      sum_d      = '0;
    end else if (accept) begin
      lane_d[byte_cnt_q] = byte_in;
      // The 2-bit position wraps to lane 0 after the fourth byte.
      byte_cnt_d         = byte_cnt_q + 2'd1;
      sum_d              = sum_q + byte_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order. The four lane bytes are
  // ordinary flops, not a RAM, so they can and do take a reset value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q <= '0;
      lane_q     <= '0;
      sum_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      lane_q     <= lane_d;
      sum_q      <= sum_d;
    end
  end

  // Decoded from the position register only, so the FSM can steer to WRITE
  // on the accepting edge without a loop through the accept input.
  assign word_full = (byte_cnt_q == 2'(WORD_BYTES - 1));
  assign checksum  = sum_q;
  assign lane_0    = lane_q[0];
  assign lane_1    = lane_q[1];
  assign lane_2    = lane_q[2];
  assign lane_3    = lane_q[3];

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Drives the load side (port B) of the instruction/data BRAM from a framed
// byte stream: 4 length bytes (LE word count N), 4*N payload bytes, 1 checksum
// byte (payload sum mod 256). One word is written per WRITE cycle.
// Parameters:
//   MEM_SIZE  : words in the target memory
//   BASE_ADDR : word address of the first written word
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   io_start                : pulse; starts a load from IDLE, DONE or ERROR
//   io_in_data/valid/ready  : byte stream handshake
//   io_en_B, io_load_we     : BRAM port-B enable / write enable (WRITE only)
//   io_instr_addr           : word address of the current write
//   io_load_data_in_0..3    : byte lanes, lane 0 = first byte of the word
//   io_busy/done/error      : load status
// All outputs come from registers or a decode of the state register.
// -----------------------------------------------------------------------------
module program_loader
  import loader_pkg::*;
#(
  parameter int MEM_SIZE  = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_start,
  input  logic [7:0]  io_in_data,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  output logic        io_en_B,
  output logic        io_load_we,
  output logic [31:0] io_instr_addr,
  output logic [7:0]  io_load_data_in_0,
  output logic [7:0]  io_load_data_in_1,
  output logic [7:0]  io_load_data_in_2,
  output logic [7:0]  io_load_data_in_3,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_error
);

  // Largest word count that still fits between BASE_ADDR and the memory end.
  localparam logic [31:0] MAX_WORDS = 32'(MEM_SIZE - BASE_ADDR);
  localparam logic [31:0] BASE_WORD = 32'(BASE_ADDR);

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  len_cnt_q, len_cnt_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [31:0] addr_q, addr_d;

  logic [31:0] new_len;
  logic [31:0] next_idx;
  logic        pk_accept;
  logic        pk_clear;
  logic        word_full;
  logic [7:0]  checksum;
  logic        restartable;

  assign restartable = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERROR);
  assign pk_clear    = restartable && io_start;
  assign pk_accept   = (state_q == ST_DATA) && io_in_valid;

  // Length bytes arrive LSB first: shifting each new byte in at the top
  // leaves the first byte in bits 7:0 after four shifts.
  assign new_len  = {io_in_data, len_q[31:8]};
  assign next_idx = word_idx_q + 32'd1;

  loader_word_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .byte_in   (io_in_data),
    .accept    (pk_accept),
    .clear     (pk_clear),
    .lane_0    (io_load_data_in_0),
    .lane_1    (io_load_data_in_1),
    .lane_2    (io_load_data_in_2),
    .lane_3    (io_load_data_in_3),
    .word_full (word_full),
    .checksum  (checksum)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    len_cnt_d  = len_cnt_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (io_start) begin
          state_d    = ST_LEN;
          len_d      = '0;
          len_cnt_d  = '0;
          word_idx_d = '0;
        end
      end

      ST_LEN: begin
        if (io_in_valid) begin
          len_d     = new_len;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'(LEN_BYTES - 1)) begin
            if ((new_len == 32'd0) || (new_len > MAX_WORDS)) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (io_in_valid && word_full) begin
          // Address is captured with the completing byte so it holds steady
          // through WRITE and afterwards.
          addr_d  = BASE_WORD + word_idx_q;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        word_idx_d = next_idx;
        state_d    = (next_idx == len_q) ? ST_CHECK : ST_DATA;
      end

      ST_CHECK: begin
        if (io_in_valid) begin
          state_d = (io_in_data == checksum) ? ST_DONE : ST_ERROR;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      len_cnt_q  <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      len_cnt_q  <= len_cnt_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
    end
  end

  assign io_in_ready   = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                         (state_q == ST_CHECK);
  assign io_en_B       = (state_q == ST_WRITE);
  assign io_load_we    = (state_q == ST_WRITE);
  assign io_busy       = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                         (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign io_done       = (state_q == ST_DONE);
  assign io_error      = (state_q == ST_ERROR);
  assign io_instr_addr = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Two loaders (BASE_ADDR 0 and 8) share one byte stream. Expected writes are
// queued per instance when a word is driven and popped by a write monitor.
// -----------------------------------------------------------------------------
module tb_program_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        reset_n;
  logic        io_start;
  logic [7:0]  io_in_data;
  logic        io_in_valid;

  logic        io_in_ready_0, io_en_B_0, io_load_we_0, io_busy_0, io_done_0, io_error_0;
  logic [31:0] io_instr_addr_0;
  logic [7:0]  l0_0, l1_0, l2_0, l3_0;
  logic        io_in_ready_8, io_en_B_8, io_load_we_8, io_busy_8, io_done_8, io_error_8;
  logic [31:0] io_instr_addr_8;
  logic [7:0]  l0_8, l1_8, l2_8, l3_8;

  int  checks = 0;
  int  errors = 0;
  wr_t q0[$];
  wr_t q8[$];
  logic we_prev_0 = 1'b0;
  logic we_prev_8 = 1'b0;

  program_loader #(.MEM_SIZE(1024), .BASE_ADDR(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .io_start(io_start),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready_0),
    .io_en_B(io_en_B_0), .io_load_we(io_load_we_0), .io_instr_addr(io_instr_addr_0),
    .io_load_data_in_0(l0_0), .io_load_data_in_1(l1_0),
    .io_load_data_in_2(l2_0), .io_load_data_in_3(l3_0),
    .io_busy(io_busy_0), .io_done(io_done_0), .io_error(io_error_0)
  );

  program_loader #(.MEM_SIZE(1024), .BASE_ADDR(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .io_start(io_start),
    .io_in_data(io_in_data), .io_in_valid(io_in_valid), .io_in_ready(io_in_ready_8),
    .io_en_B(io_en_B_8), .io_load_we(io_load_we_8), .io_instr_addr(io_instr_addr_8),
    .io_load_data_in_0(l0_8), .io_load_data_in_1(l1_8),
    .io_load_data_in_2(l2_8), .io_load_data_in_3(l3_8),
    .io_busy(io_busy_8), .io_done(io_done_8), .io_error(io_error_8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitors: every WRITE cycle must match the oldest queued word.
  always @(negedge clock) begin
    if (io_load_we_0) begin
      check("w0_en_b", io_en_B_0, 1);
      check("w0_ready_low", io_in_ready_0, 0);
      check("w0_single_cycle", we_prev_0, 0);
      check("w0_expected", 64'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        wr_t e;
        e = q0.pop_front();
        check("w0_addr", io_instr_addr_0, e.addr);
        check("w0_data", {l3_0, l2_0, l1_0, l0_0}, e.data);
      end
    end
    we_prev_0 = io_load_we_0;
  end

  always @(negedge clock) begin
    if (io_load_we_8) begin
      check("w8_en_b", io_en_B_8, 1);
      check("w8_ready_low", io_in_ready_8, 0);
      check("w8_single_cycle", we_prev_8, 0);
      check("w8_expected", 64'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        wr_t e;
        e = q8.pop_front();
        check("w8_addr", io_instr_addr_8, e.addr);
        check("w8_data", {l3_8, l2_8, l1_8, l0_8}, e.data);
      end
    end
    we_prev_8 = io_load_we_8;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] sum8(input logic [7:0] pl[$]);
    logic [7:0] s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    return s;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl0"}, {io_in_ready_0, io_en_B_0, io_load_we_0, io_busy_0, io_done_0, io_error_0}, 0);
    check({tag, "_addr0"}, io_instr_addr_0, 0);
    check({tag, "_lanes0"}, {l3_0, l2_0, l1_0, l0_0}, 0);
    check({tag, "_ctl8"}, {io_in_ready_8, io_en_B_8, io_load_we_8, io_busy_8, io_done_8, io_error_8}, 0);
    check({tag, "_addr8"}, io_instr_addr_8, 0);
    check({tag, "_lanes8"}, {l3_8, l2_8, l1_8, l0_8}, 0);
  endtask

  // Expected {ready, busy, done, error} for both instances.
  task automatic check_status(input string tag, input logic [3:0] exp);
    check({tag, "_st0"}, {io_in_ready_0, io_busy_0, io_done_0, io_error_0}, exp);
    check({tag, "_st8"}, {io_in_ready_8, io_busy_8, io_done_8, io_error_8}, exp);
    check({tag, "_pending0"}, q0.size(), 0);
    check({tag, "_pending8"}, q8.size(), 0);
  endtask

  task automatic pulse_start();
    io_start = 1'b1;
    @(posedge clock); #1;
    io_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int waits = 0;
    bit took = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        io_in_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
    io_in_data  = b;
    io_in_valid = 1'b1;
    while (!took && waits < 64) begin
      @(negedge clock);
      if (io_in_ready_0) took = 1;
      else waits++;
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0;
    check("byte_accepted", took, 1);
  endtask

  task automatic send_len(input logic [31:0] n, input bit rnd);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], rnd);
  endtask

  // Drives a full frame with a valid length; queues the expected writes.
  task automatic send_frame(input logic [31:0] n, input logic [7:0] pl[$],
                            input logic [7:0] cks, input bit rnd, input bit mid_start);
    send_len(n, rnd);
    for (int k = 0; k < int'(n); k++) begin
      logic [31:0] w;
      w = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
      q0.push_back('{addr: 32'(k), data: w});
      q8.push_back('{addr: 32'(8 + k), data: w});
      for (int j = 0; j < 4; j++) send_byte(pl[4*k+j], rnd);
      check("write_follows_word", io_load_we_0, 1);
      if (mid_start && k == 1) begin
        pulse_start();   // lands on the WRITE edge
        pulse_start();   // lands in DATA
        check("start_ignored_busy", io_busy_0, 1);
      end
    end
    send_byte(cks, rnd);
  endtask

  initial begin
    logic [7:0] pl[$];
    reset_n     = 1'b0;
    io_start    = 1'b0;
    io_in_data  = 8'h00;
    io_in_valid = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Single word 11 22 33 44, checksum AA.
    pulse_start();
    check("start_ready", io_in_ready_0, 1);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(32'd1, pl, 8'hAA, 0, 0);
    check_status("one_word", 4'b0010);

    // Three words 00..0B, checksum 42.
    pulse_start();
    pl = {};
    for (int i = 0; i < 12; i++) pl.push_back(8'(i));
    check("model_sum_42", sum8(pl), 8'h42);
    send_frame(32'd3, pl, 8'h42, 0, 0);
    check_status("three_words", 4'b0010);

    // Two words with a wrong checksum byte.
    pulse_start();
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'hA0 + 8'(i));
    send_frame(32'd2, pl, ~sum8(pl) == 8'hFF ? 8'hFE : 8'hFF, 0, 0);
    check_status("bad_checksum", 4'b0001);

    // Zero length and over-size length are rejected without writing.
    pulse_start();
    send_len(32'd0, 0);
    check_status("len_zero", 4'b0001);
    pulse_start();
    send_len(32'd1025, 0);
    check_status("len_too_big", 4'b0001);

    // Reset after 6 payload bytes of a 2-word frame: only word 0 is written.
    pulse_start();
    send_len(32'd2, 0);
    pl = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'h77, 8'h66};
    q0.push_back('{addr: 32'd0, data: 32'h8001C35A});
    q8.push_back('{addr: 32'd8, data: 32'h8001C35A});
    for (int i = 0; i < 6; i++) send_byte(pl[i], 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    check_status("after_reset", 4'b0000);
    pulse_start();
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(32'd1, pl, sum8(pl), 0, 0);
    check_status("fresh_frame", 4'b0010);

    // Four words, random valid gaps, start pulses mid-load.
    pulse_start();
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_frame(32'd4, pl, sum8(pl), 1, 1);
    check_status("random_valid", 4'b0010);

    // Bytes offered in DONE are refused.
    io_in_data  = 8'h99;
    io_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("ready_in_done", io_in_ready_0, 0);
    end
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    check_status("still_done", 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
